// File: rtl/alu_seq_pkg.sv
// Shared encodings for the ALU sequencer: primitive ALU ops, high-level commands and FSM states.
package alu_seq_pkg;

  typedef enum logic [1:0] {
    AluXor = 2'b00,
    AluAdd = 2'b01,
    AluSub = 2'b10,
    AluSlt = 2'b11
  } alu_op_e;

  typedef enum logic [1:0] {
    CmdMul     = 2'b00,
    CmdAbsdiff = 2'b01,
    CmdMax     = 2'b10,
    CmdMin     = 2'b11
  } cmd_op_e;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StRun  = 2'b01,
    StResp = 2'b10
  } state_e;

endpackage

// File: rtl/alu_seq.sv
// Multi-cycle command sequencer driving an external combinational ALU one primitive per cycle.
// Optional ALU_SEQ_EQ_SHORTCUT_EN: ABSDIFF of equal operands finishes after the SLT step.
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int unsigned width = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [width-1:0] cmd_a,
  input  logic [width-1:0] cmd_b,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [width-1:0] rsp_data,
  output logic [1:0]       alu_op,
  output logic [width-1:0] alu_a,
  output logic [width-1:0] alu_b,
  input  logic [width-1:0] alu_out,
  input  logic             alu_eq
);

  localparam int unsigned StepW = $clog2(width) + 1;
  localparam logic [StepW-1:0] MulLast = StepW'(width - 1);

  state_e           state_q;
  cmd_op_e          op_q;
  logic [StepW-1:0] step_q;
  logic [width-1:0] a_q;
  logic [width-1:0] b_q;
  logic [width-1:0] acc_q;
  logic [width-1:0] rsp_data_q;
  logic             lt_q;
  alu_op_e          alu_op_d;

`ifndef ALU_SEQ_EQ_SHORTCUT_EN
  logic unused_eq;
  assign unused_eq = alu_eq;
`endif

  assign cmd_ready = (state_q == StIdle);
  assign rsp_valid = (state_q == StResp);
  assign rsp_data  = rsp_data_q;
  assign alu_op    = alu_op_d;

  // ALU drive is a pure function of registered state; idle value is XOR(0,0).
  always_comb begin
    alu_op_d = AluXor;
    alu_a    = '0;
    alu_b    = '0;
    if (state_q == StRun) begin
      unique case (op_q)
        CmdMul: begin
          alu_op_d = AluAdd;
          alu_a    = acc_q;
          alu_b    = b_q[0] ? a_q : '0;
        end
        CmdAbsdiff: begin
          if (step_q == '0) begin
            alu_op_d = AluSlt;
            alu_a    = a_q;
            alu_b    = b_q;
          end else begin
            alu_op_d = AluSub;
            alu_a    = lt_q ? b_q : a_q;
            alu_b    = lt_q ? a_q : b_q;
          end
        end
        CmdMax, CmdMin: begin
          alu_op_d = AluSlt;
          alu_a    = a_q;
          alu_b    = b_q;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= StIdle;
      op_q       <= CmdMul;
      step_q     <= '0;
      a_q        <= '0;
      b_q        <= '0;
      acc_q      <= '0;
      rsp_data_q <= '0;
      lt_q       <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (cmd_valid) begin
            state_q <= StRun;
            op_q    <= cmd_op_e'(cmd_op);
            a_q     <= cmd_a;
            b_q     <= cmd_b;
            acc_q   <= '0;
            step_q  <= '0;
            lt_q    <= 1'b0;
          end
        end
        StRun: begin
          step_q <= step_q + StepW'(1);
          unique case (op_q)
            CmdMul: begin
              // a_q is the shifting multiplicand, b_q the shifting multiplier.
              acc_q <= alu_out;
              a_q   <= a_q << 1;
              b_q   <= b_q >> 1;
              if (step_q == MulLast) begin
                rsp_data_q <= alu_out;
                state_q    <= StResp;
              end
            end
            CmdAbsdiff: begin
              if (step_q == '0) begin
                lt_q <= alu_out[0];
`ifdef ALU_SEQ_EQ_SHORTCUT_EN
                if (alu_eq) begin
                  rsp_data_q <= '0;
                  state_q    <= StResp;
                end
`endif
              end else begin
                rsp_data_q <= alu_out;
                state_q    <= StResp;
              end
            end
            CmdMax: begin
              rsp_data_q <= alu_out[0] ? b_q : a_q;
              state_q    <= StResp;
            end
            CmdMin: begin
              rsp_data_q <= alu_out[0] ? a_q : b_q;
              state_q    <= StResp;
            end
          endcase
        end
        StResp: begin
          if (rsp_ready) begin
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Directed self-checking bench for alu_seq; a small behavioural ALU closes the op/A/B loop.
module tb_alu_seq;

  localparam int unsigned W = 32;
  localparam logic [1:0] OpMul = 2'b00, OpAbs = 2'b01, OpMax = 2'b10, OpMin = 2'b11;
  localparam logic [1:0] AXor = 2'b00, AAdd = 2'b01, ASub = 2'b10, ASlt = 2'b11;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         cmd_valid = 1'b0;
  logic         cmd_ready;
  logic [1:0]   cmd_op = 2'b00;
  logic [W-1:0] cmd_a = '0;
  logic [W-1:0] cmd_b = '0;
  logic         rsp_valid;
  logic         rsp_ready = 1'b1;
  logic [W-1:0] rsp_data;
  logic [1:0]   alu_op;
  logic [W-1:0] alu_a;
  logic [W-1:0] alu_b;
  logic [W-1:0] alu_out;
  logic         alu_eq;

  int total = 0;
  int bad = 0;
  int cycles = 0;
  logic [1:0]   op_log [0:127];
  logic [W-1:0] a_log  [0:127];
  logic [W-1:0] b_log  [0:127];

  always #5 clk = ~clk;

  alu_seq #(.width(W)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_a     (cmd_a),
    .cmd_b     (cmd_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .alu_op    (alu_op),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_out   (alu_out),
    .alu_eq    (alu_eq)
  );

  // Reference combinational ALU
  always_comb begin
    alu_out = '0;
    case (alu_op)
      AXor: alu_out = alu_a ^ alu_b;
      AAdd: alu_out = alu_a + alu_b;
      ASub: alu_out = alu_a - alu_b;
      ASlt: alu_out = {{(W-1){1'b0}}, ($signed(alu_a) < $signed(alu_b))};
      default: alu_out = '0;
    endcase
    alu_eq = (alu_a == alu_b);
  end

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present a command at the falling edge; returns #1 after the accepting edge.
  task automatic start_cmd(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_a     = a;
    cmd_b     = b;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  // Log ALU drive each RUN cycle until rsp_valid; cycles ends as the observed latency.
  task automatic wait_rsp();
    cycles = 0;
    while (rsp_valid !== 1'b1 && cycles < 100) begin
      op_log[cycles] = alu_op;
      a_log[cycles]  = alu_a;
      b_log[cycles]  = alu_b;
      @(posedge clk);
      #1;
      cycles++;
    end
  endtask

  task automatic finish_rsp(input string tag);
    @(posedge clk);
    #1;
    check({tag, "_rsp_valid_drop"}, W'(rsp_valid), W'(0));
    check({tag, "_cmd_ready_back"}, W'(cmd_ready), W'(1));
  endtask

  initial begin
    int nonadd;

    // Reset state
    #1;
    check("rst_cmd_ready", W'(cmd_ready), W'(1));
    check("rst_rsp_valid", W'(rsp_valid), W'(0));
    check("rst_rsp_data", rsp_data, '0);
    check("rst_alu_op", W'(alu_op), W'(0));
    check("rst_alu_ab", alu_a | alu_b, '0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;

    // MUL 7*6
    start_cmd(OpMul, 32'd7, 32'd6);
    wait_rsp();
    check("mul76_lat", cycles, 32);
    check("mul76_data", rsp_data, 32'd42);
    nonadd = 0;
    for (int i = 0; i < cycles; i++) if (op_log[i] !== AAdd) nonadd++;
    check("mul76_all_add", nonadd, 0);
    finish_rsp("mul76");

    // MUL wrap
    start_cmd(OpMul, 32'hFFFF_FFFF, 32'd2);
    wait_rsp();
    check("mulwrap_lat", cycles, 32);
    check("mulwrap_data", rsp_data, 32'hFFFF_FFFE);
    finish_rsp("mulwrap");

    // MUL signed: -3 * 5
    start_cmd(OpMul, 32'hFFFF_FFFD, 32'd5);
    wait_rsp();
    check("mulneg_data", rsp_data, 32'hFFFF_FFF1);
    finish_rsp("mulneg");

    // ABSDIFF 3,10
    start_cmd(OpAbs, 32'd3, 32'd10);
    wait_rsp();
    check("abs1_lat", cycles, 2);
    check("abs1_data", rsp_data, 32'd7);
    check("abs1_op0", W'(op_log[0]), W'(ASlt));
    check("abs1_op1", W'(op_log[1]), W'(ASub));
    check("abs1_a1", a_log[1], 32'd10);
    check("abs1_b1", b_log[1], 32'd3);
    finish_rsp("abs1");

    // ABSDIFF -5,4
    start_cmd(OpAbs, 32'hFFFF_FFFB, 32'd4);
    wait_rsp();
    check("abs2_data", rsp_data, 32'd9);
    check("abs2_op1", W'(op_log[1]), W'(ASub));
    check("abs2_a1", a_log[1], 32'd4);
    check("abs2_b1", b_log[1], 32'hFFFF_FFFB);
    finish_rsp("abs2");

    // ABSDIFF equal operands
    start_cmd(OpAbs, 32'd9, 32'd9);
    wait_rsp();
`ifdef ALU_SEQ_EQ_SHORTCUT_EN
    check("abseq_lat", cycles, 1);
`else
    check("abseq_lat", cycles, 2);
`endif
    check("abseq_data", rsp_data, 32'd0);
    finish_rsp("abseq");

    // ABSDIFF MIN_INT,0 wraps to MIN_INT
    start_cmd(OpAbs, 32'h8000_0000, 32'd0);
    wait_rsp();
    check("absmin_data", rsp_data, 32'h8000_0000);
    finish_rsp("absmin");

    // MAX -1,1 with consumer stalled for 5 cycles
    rsp_ready = 1'b0;
    start_cmd(OpMax, 32'hFFFF_FFFF, 32'd1);
    wait_rsp();
    check("max_lat", cycles, 1);
    check("max_op0", W'(op_log[0]), W'(ASlt));
    check("max_data", rsp_data, 32'd1);
    cmd_valid = 1'b1;
    cmd_op    = OpMin;
    cmd_a     = 32'hFFFF_FFFF;
    cmd_b     = 32'd1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      check("hold_data", rsp_data, 32'd1);
      check("hold_cmd_ready", W'(cmd_ready), W'(0));
      check("hold_rsp_valid", W'(rsp_valid), W'(1));
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    check("rel_rsp_valid", W'(rsp_valid), W'(0));
    check("rel_cmd_ready", W'(cmd_ready), W'(1));
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    check("next_accept", W'(cmd_ready), W'(0));
    wait_rsp();
    check("min_lat", cycles, 1);
    check("min_op0", W'(op_log[0]), W'(ASlt));
    check("min_data", rsp_data, 32'hFFFF_FFFF);
    finish_rsp("min");

    // Reset during MUL step 10
    start_cmd(OpMul, 32'd123, 32'd456);
    repeat (10) @(posedge clk);
    #1;
    check("mid_mul_op", W'(alu_op), W'(AAdd));
    reset_n = 1'b0;
    #1;
    check("abort_rsp_valid", W'(rsp_valid), W'(0));
    check("abort_cmd_ready", W'(cmd_ready), W'(1));
    check("abort_rsp_data", rsp_data, '0);
    check("abort_alu_op", W'(alu_op), W'(AXor));
    check("abort_alu_ab", alu_a | alu_b, '0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("abort_no_rsp", W'(rsp_valid), W'(0));
    start_cmd(OpMax, 32'd2, 32'd5);
    wait_rsp();
    check("post_max_lat", cycles, 1);
    check("post_max_data", rsp_data, 32'd5);
    finish_rsp("post_max");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
